gmii_payload_extract: RTL and testbench
=======================================

// Module: gmii_payload_extract
// PURPOSE
//  Receive-side framer between the GMII RX pins (after IDDR/sync) and detect_errors2.
//  Strips preamble/SFD, the Ethernet header and the 4-byte FCS.
//  Presents each frame's payload as a contiguous rx_en/rx_data burst; payload byte 0 is the first byte after the header.
//  Keeps frame/drop statistics for the error-rate path. Single 125 MHz GMII RX clock domain.
// PARAMETERS
//  HEADER_BYTES  14    bytes after SFD discarded before payload (MAC dst/src + ethertype)
//  FCS_BYTES     4     trailing bytes withheld and discarded; fixed delay-line depth
//  MAX_PAYLOAD   1500  max payload bytes; frames longer than MAX_PAYLOAD+FCS_BYTES after the header are aborted
// PORTS
//  clk          in   1   GMII RX clock, 125 MHz
//  rst_n        in   1   asynchronous active-low reset
//  gmii_rx_dv   in   1   receive data valid
//  gmii_rx_er   in   1   receive error
//  gmii_rxd     in   8   receive data
//  rx_en        out  1   payload byte valid (feeds detect_errors2.rx_en)
//  rx_data      out  8   payload byte (feeds detect_errors2.rx_data)
//  frame_done   out  1   1-cycle pulse: frame completed without error
//  frame_err    out  1   1-cycle pulse: frame aborted (rx_er, bad preamble, runt, oversize)
//  pkt_count    out  32  good frames, wraps at 2^32
//  drop_count   out  32  aborted frames, wraps at 2^32
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, delay line cleared, FSM in DROP.
//   Reset mid-frame therefore discards the rest of that frame.
//  FSM (all transitions on clk):
//   DROP      -> IDLE when gmii_rx_dv==0.
//   IDLE      -> PREAMBLE on dv==1 && rxd==8'h55; dv==1 with any other byte -> DROP + error.
//   PREAMBLE  -> stays on 8'h55; -> HEADER on 8'hD5; other byte, rx_er or dv==0 -> error.
//   HEADER    -> counts HEADER_BYTES bytes, then -> PAYLOAD; dv==0 or rx_er before the count completes -> error.
//   PAYLOAD   -> shifts each byte into a FCS_BYTES-deep delay line.
//                dv==0 -> IDLE, with frame_done if fill==FCS_BYTES, else error (runt).
//                rx_er -> error. Byte count > MAX_PAYLOAD+FCS_BYTES -> error.
//   error:    frame_err pulse, drop_count+1, rx_en forced 0 the next cycle.
//             Go to DROP if dv still 1, else IDLE.
//  Output timing:
//   Once the delay line holds FCS_BYTES bytes, each new payload input byte causes the oldest byte to be registered out.
//   Payload byte k arriving at cycle t appears on rx_data with rx_en=1 at cycle t+FCS_BYTES+1.
//   rx_en is contiguous for an unbroken dv stream. The final FCS_BYTES bytes are never emitted.
//   rx_data holds its last value when rx_en=0.
//  Frame end:
//   frame_done asserts the cycle after dv falls, which is also the first cycle with rx_en=0.
//   pkt_count increments in that same cycle.
//  Priorities and corner cases:
//   rx_er has priority over dv falling in the same cycle.
//   rx_er with dv==0 is ignored (carrier extension).
//   frame_done and frame_err are mutually exclusive.
//  Back-to-back frames: one idle dv cycle is sufficient. rx_en is low for at least 1 cycle between frames.
//  Payload of exactly 0 bytes (header+FCS only) is a good frame: frame_done=1, no rx_en.
// TESTING
//  1. 7x55,D5, 14 hdr, 33 payload (00..20), 4 FCS.
//     -> rx_en high 33 consecutive cycles, first at 5 cycles after payload byte 0.
//     -> rx_data 00..20 in order; frame_done once; pkt_count=1.
//  2. 89 frames of 33-byte payload, dv gap 6 cycles.
//     -> 89 rx_en bursts of 33; pkt_count=89; drop_count=0; no frame_err.
//  3. rx_er=1 on payload byte 10.
//     -> rx_en low next cycle; frame_err pulse; drop_count=1.
//     -> Next clean frame is fully delivered.
//  4. Preamble 55,55,AA,D5...
//     -> no rx_en for that frame; frame_err; drop_count=1; recovers on next frame.
//  5. dv falls after 14 hdr + 2 bytes (runt) -> frame_err, no rx_en, pkt_count unchanged.
//  6. rst_n low for 2 cycles mid-payload.
//     -> outputs 0 immediately; remainder of the frame ignored; next frame received normally.

Source files
------------

// File: rtl/gmii_payload_extract_if.sv
// Signal bundle between the GMII receive pins and the payload consumer
// (detect_errors2), plus frame statistics and a debug view of the framer.
interface gmii_payload_extract_if;
    // Valid-only handshake, no backpressure: gmii_rxd is consumed on every clk edge
    // with gmii_rx_dv=1, and rx_data must be taken by the sink on every edge with rx_en=1.
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic        frame_done;
    logic        frame_err;
    logic [31:0] pkt_count;
    logic [31:0] drop_count;
    logic [2:0]  fsm_state;

    modport master (
        output gmii_rx_dv, gmii_rx_er, gmii_rxd,
        input  rx_en, rx_data, frame_done, frame_err, pkt_count, drop_count, fsm_state
    );

    modport slave (
        input  gmii_rx_dv, gmii_rx_er, gmii_rxd,
        output rx_en, rx_data, frame_done, frame_err, pkt_count, drop_count, fsm_state
    );
endinterface

// File: rtl/gmii_payload_extract.sv
// GMII receive framer: strips preamble/SFD, header and FCS, emits the payload as a
// contiguous rx_en burst and counts good and aborted frames.
module gmii_payload_extract #(
    parameter int HEADER_BYTES = 14,
    parameter int FCS_BYTES    = 4,
    parameter int MAX_PAYLOAD  = 1500
) (
    input logic                   clk,
    input logic                   rst_n,
    gmii_payload_extract_if.slave bus
);
    localparam logic [2:0] S_DROP     = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_PREAMBLE = 3'd2;
    localparam logic [2:0] S_HEADER   = 3'd3;
    localparam logic [2:0] S_PAYLOAD  = 3'd4;

    localparam int HDR_W  = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
    localparam int FILL_W = $clog2(FCS_BYTES + 1);
    localparam int CNT_W  = $clog2(MAX_PAYLOAD + FCS_BYTES + 1);

    localparam logic [HDR_W-1:0]  HDR_LAST  = HDR_W'(HEADER_BYTES - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FCS_BYTES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_PAYLOAD + FCS_BYTES);

    logic              dv;
    logic              er;
    logic [7:0]        rxd;

    logic [2:0]        state_q, state_d;
    logic [HDR_W-1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]        dl_q [FCS_BYTES];
    logic              rx_en_q, rx_en_d;
    logic [7:0]        rx_data_q;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic [31:0]       pkt_count_q, pkt_count_d;
    logic [31:0]       drop_count_q, drop_count_d;
    logic              shift_en;

    assign dv  = bus.gmii_rx_dv;
    assign er  = bus.gmii_rx_er;
    assign rxd = bus.gmii_rxd;

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        fill_d       = fill_q;
        byte_cnt_d   = byte_cnt_q;
        shift_en     = 1'b0;
        rx_en_d      = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            S_DROP: begin
                if (!dv) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (dv) begin
                    if (rxd == 8'h55) state_d = S_PREAMBLE;
                    else              frame_err_d = 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (!dv || er) begin
                    frame_err_d = 1'b1;
                end else if (rxd == 8'hD5) begin
                    state_d   = S_HEADER;
                    hdr_cnt_d = '0;
                end else if (rxd != 8'h55) begin
                    frame_err_d = 1'b1;
                end
            end
            S_HEADER: begin
                if (!dv || er) begin
                    frame_err_d = 1'b1;
                end else if (hdr_cnt_q == HDR_LAST) begin
                    state_d    = S_PAYLOAD;
                    fill_d     = '0;
                    byte_cnt_d = '0;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
                end
            end
            S_PAYLOAD: begin
                // rx_er wins over the end of the frame, even when dv drops in the same cycle.
                if (er) begin
                    frame_err_d = 1'b1;
                end else if (!dv) begin
                    state_d = S_IDLE;
                    if (fill_q == FILL_FULL) frame_done_d = 1'b1;
                    else                     frame_err_d  = 1'b1;
                end else if (byte_cnt_q == CNT_MAX) begin
                    frame_err_d = 1'b1;
                end else begin
                    shift_en   = 1'b1;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (fill_q == FILL_FULL) rx_en_d = 1'b1;
                    else                     fill_d  = fill_q + FILL_W'(1);
                end
            end
            default: state_d = S_DROP;
        endcase

        if (frame_err_d) state_d = dv ? S_DROP : S_IDLE;

        pkt_count_d  = pkt_count_q + 32'(frame_done_d);
        drop_count_d = drop_count_q + 32'(frame_err_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_DROP;
            hdr_cnt_q    <= '0;
            fill_q       <= '0;
            byte_cnt_q   <= '0;
            rx_en_q      <= 1'b0;
            rx_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            for (int i = 0; i < FCS_BYTES; i++) dl_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            fill_q       <= fill_d;
            byte_cnt_q   <= byte_cnt_d;
            rx_en_q      <= rx_en_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            // The oldest byte leaves the delay line only once FCS_BYTES newer bytes exist,
            // so the trailing FCS never reaches rx_data.
            if (rx_en_d) rx_data_q <= dl_q[FCS_BYTES-1];
            if (shift_en) begin
                dl_q[0] <= rxd;
                for (int i = 1; i < FCS_BYTES; i++) dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign bus.rx_en      = rx_en_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.pkt_count  = pkt_count_q;
    assign bus.drop_count = drop_count_q;
    assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_gmii_payload_extract.sv
// Bench for gmii_payload_extract: directed frames, a cycle-stamped payload/pulse model
// and literal expectations for burst lengths, latency and counters.
module tb_gmii_payload_extract;
    localparam int HDR  = 14;
    localparam int FCS  = 4;
    localparam int MAXP = 1500;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    gmii_payload_extract_if bus();

    gmii_payload_extract #(
        .HEADER_BYTES(HDR),
        .FCS_BYTES   (FCS),
        .MAX_PAYLOAD (MAXP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Clock / reset block
    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: expected payload bytes stamped with the cycle they must appear in
    logic [39:0] exp_q[$];
    int          done_q[$];
    int          err_q[$];
    int          mdl_pkt      = 0;
    int          mdl_drop     = 0;
    logic [7:0]  last_data    = 8'h00;
    int          en_cnt       = 0;
    int          first_en_cyc = -1;
    int          pay0_cyc     = 0;
    int          drv_cyc      = 0;
    int          mark         = 0;

    logic [39:0] cmp_e;
    bit          cmp_en;
    bit          cmp_done;
    bit          cmp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard / compare process
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            cmp_en = 1'b0;
            cmp_e  = '0;
            if (exp_q.size() > 0) begin
                cmp_e = exp_q[0];
                if (cmp_e[39:8] == 32'(cyc)) begin
                    cmp_en = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
            if (cmp_en || bus.rx_en) begin
                check("rx_en", 32'(bus.rx_en), 32'(cmp_en));
                if (cmp_en) begin
                    check("rx_data", 32'(bus.rx_data), 32'(cmp_e[7:0]));
                    last_data = cmp_e[7:0];
                end
            end
            if (bus.rx_en) begin
                en_cnt++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end

            cmp_done = (done_q.size() > 0) && (done_q[0] == cyc);
            cmp_err  = (err_q.size() > 0) && (err_q[0] == cyc);
            if (cmp_done) begin void'(done_q.pop_front()); mdl_pkt++; end
            if (cmp_err)  begin void'(err_q.pop_front());  mdl_drop++; end
            if (cmp_done || bus.frame_done) check("frame_done", 32'(bus.frame_done), 32'(cmp_done));
            if (cmp_err || bus.frame_err)   check("frame_err", 32'(bus.frame_err), 32'(cmp_err));
            if (cmp_done || cmp_err || bus.frame_done || bus.frame_err) begin
                check("pkt_count", bus.pkt_count, 32'(mdl_pkt));
                check("drop_count", bus.drop_count, 32'(mdl_drop));
                check("rx_data_hold", 32'(bus.rx_data), 32'(last_data));
            end
        end
    end

    // Driver tasks
    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk);
        bus.gmii_rx_dv = dv;
        bus.gmii_rx_er = er;
        bus.gmii_rxd   = d;
        drv_cyc        = cyc;
    endtask

    task automatic apply_reset_now();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        err_q.delete();
        mdl_pkt   = 0;
        mdl_drop  = 0;
        last_data = 8'h00;
        #1;
        check("rst_rx_en", 32'(bus.rx_en), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_pkt_count", bus.pkt_count, 32'd0);
        check("rst_drop_count", bus.drop_count, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One frame: n_pre preamble bytes (bad_pre index replaced by 8'hAA), SFD, n_hdr header
    // bytes, n_pay post-header bytes (payload+FCS, value seed+k), then gap idle cycles.
    // er_idx / rst_idx place an rx_er or a 2-cycle reset on that post-header byte.
    task automatic send_frame(input int n_pre, input int bad_pre, input int n_hdr, input int n_pay,
                              input int er_idx, input int rst_idx, input logic [7:0] seed,
                              input int gap);
        int t_arr[$];
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < n_pre; i++) begin
            if (i == bad_pre) begin
                drive(1'b1, 1'b0, 8'hAA);
                if (ok) err_q.push_back(drv_cyc + 1);
                ok = 1'b0;
            end else begin
                drive(1'b1, 1'b0, 8'h55);
            end
        end
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < n_hdr; i++) drive(1'b1, 1'b0, 8'(16 + i));
        for (int k = 0; k < n_pay; k++) begin
            if (k == rst_idx) begin
                apply_reset_now();
                ok = 1'b0;
            end
            if (rst_idx >= 0 && k == rst_idx + 2) release_reset();
            drive(1'b1, (k == er_idx), 8'(seed + k));
            t_arr.push_back(drv_cyc);
            if (k == 0) pay0_cyc = drv_cyc;
            if (ok) begin
                if (k == er_idx) begin
                    err_q.push_back(drv_cyc + 1);
                    ok = 1'b0;
                end else if (k >= MAXP + FCS) begin
                    err_q.push_back(drv_cyc + 1);
                    ok = 1'b0;
                end else if (k >= FCS) begin
                    exp_q.push_back({32'(t_arr[k-FCS] + FCS + 1), 8'(seed + k - FCS)});
                end
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        if (ok) begin
            if (n_hdr < HDR || n_pay < FCS) err_q.push_back(drv_cyc + 1);
            else                            done_q.push_back(drv_cyc + 1);
        end
        for (int g = 1; g < gap; g++) drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #(8 * 60000);
        tests++;
        fails++;
        $display("FAIL watchdog: cycle %0d reached, expected completion earlier", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rx_er = 1'b0;
        bus.gmii_rxd   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("init_rx_en", 32'(bus.rx_en), 32'd0);
        check("init_rx_data", 32'(bus.rx_data), 32'd0);
        check("init_frame_done", 32'(bus.frame_done), 32'd0);
        check("init_frame_err", 32'(bus.frame_err), 32'd0);
        check("init_pkt_count", bus.pkt_count, 32'd0);
        check("init_drop_count", bus.drop_count, 32'd0);
        release_reset();
        repeat (2) drive(1'b0, 1'b0, 8'h00);

        // Single frame, payload 00..20
        first_en_cyc = -1;
        mark = en_cnt;
        send_frame(7, -1, HDR, 33 + FCS, -1, -1, 8'h00, 6);
        check("t1_burst_len", 32'(en_cnt - mark), 32'd33);
        check("t1_first_latency", 32'(first_en_cyc - pay0_cyc), 32'd5);
        check("t1_last_byte", 32'(bus.rx_data), 32'h20);
        check("t1_pkt_count", bus.pkt_count, 32'd1);

        // 89 frames with a 6-cycle gap
        mark = en_cnt;
        for (int i = 0; i < 89; i++) send_frame(7, -1, HDR, 37, -1, -1, 8'(i * 3), 6);
        check("t2_rx_en_total", 32'(en_cnt - mark), 32'd2937);
        check("t2_pkt_count", bus.pkt_count, 32'd90);
        check("t2_drop_count", bus.drop_count, 32'd0);

        // rx_er on payload byte 10, then a clean frame
        mark = en_cnt;
        send_frame(7, -1, HDR, 37, 10, -1, 8'h40, 6);
        check("t3_rx_en_before_err", 32'(en_cnt - mark), 32'd6);
        check("t3_drop_count", bus.drop_count, 32'd1);
        mark = en_cnt;
        send_frame(7, -1, HDR, 37, -1, -1, 8'h60, 6);
        check("t3_recover_len", 32'(en_cnt - mark), 32'd33);
        check("t3_pkt_count", bus.pkt_count, 32'd91);

        // Bad preamble 55,55,AA,D5, then a clean frame
        mark = en_cnt;
        send_frame(3, 2, HDR, 37, -1, -1, 8'h80, 6);
        check("t4_rx_en", 32'(en_cnt - mark), 32'd0);
        check("t4_drop_count", bus.drop_count, 32'd2);
        send_frame(7, -1, HDR, 37, -1, -1, 8'h90, 6);
        check("t4_pkt_count", bus.pkt_count, 32'd92);

        // Runt: header plus 2 bytes
        mark = en_cnt;
        send_frame(7, -1, HDR, 2, -1, -1, 8'hA0, 6);
        check("t5_rx_en", 32'(en_cnt - mark), 32'd0);
        check("t5_drop_count", bus.drop_count, 32'd3);
        check("t5_pkt_count", bus.pkt_count, 32'd92);

        // Zero-byte payload (header + FCS only) is a good frame
        mark = en_cnt;
        send_frame(7, -1, HDR, FCS, -1, -1, 8'hB0, 6);
        check("zero_pay_rx_en", 32'(en_cnt - mark), 32'd0);
        check("zero_pay_pkt_count", bus.pkt_count, 32'd93);

        // dv falls inside the header
        send_frame(7, -1, 5, 0, -1, -1, 8'h00, 6);
        check("hdr_abort_drop_count", bus.drop_count, 32'd4);

        // Back-to-back with a single idle cycle, then carrier extension (rx_er with dv=0)
        mark = en_cnt;
        send_frame(7, -1, HDR, 37, -1, -1, 8'h11, 1);
        send_frame(7, -1, HDR, 37, -1, -1, 8'h22, 1);
        repeat (3) drive(1'b0, 1'b1, 8'h0F);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        check("b2b_rx_en_total", 32'(en_cnt - mark), 32'd66);
        check("b2b_pkt_count", bus.pkt_count, 32'd95);
        check("carrier_ext_drop_count", bus.drop_count, 32'd4);

        // Largest legal frame, then one byte too long
        mark = en_cnt;
        send_frame(7, -1, HDR, MAXP + FCS, -1, -1, 8'h33, 6);
        check("max_rx_en", 32'(en_cnt - mark), 32'd1500);
        check("max_pkt_count", bus.pkt_count, 32'd96);
        mark = en_cnt;
        send_frame(7, -1, HDR, MAXP + FCS + 1, -1, -1, 8'h44, 6);
        check("oversize_rx_en", 32'(en_cnt - mark), 32'd1500);
        check("oversize_drop_count", bus.drop_count, 32'd5);
        check("oversize_pkt_count", bus.pkt_count, 32'd96);

        // Reset for 2 cycles mid-payload, then a clean frame
        send_frame(7, -1, HDR, 37, -1, 15, 8'h55, 6);
        check("t6_pkt_after_rst", bus.pkt_count, 32'd0);
        check("t6_drop_after_rst", bus.drop_count, 32'd0);
        mark = en_cnt;
        send_frame(7, -1, HDR, 37, -1, -1, 8'h70, 6);
        check("t6_recover_len", 32'(en_cnt - mark), 32'd33);
        check("t6_pkt_count", bus.pkt_count, 32'd1);
        check("t6_drop_count", bus.drop_count, 32'd0);

        repeat (4) drive(1'b0, 1'b0, 8'h00);
        check("pending_bytes", 32'(exp_q.size()), 32'd0);
        check("pending_done", 32'(done_q.size()), 32'd0);
        check("pending_err", 32'(err_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
